// File: rtl/gaus_box_muller_ctrl.sv
// gaus_box_muller_ctrl
// Requester side of the sqrt(-2ln u) log table and core of a Box-Muller AWGN
// source. Two Galois LFSRs supply table addresses, cosine phase and sign. The
// 2-cycle table return is scaled by a quarter-wave cosine, then rounded and
// saturated to two signed Gaussian samples per enabled cycle.
// Optional build macro GAUS_BM_SEED_LOAD_EN adds a runtime seed-load port.
module gaus_box_muller_ctrl #(
  parameter int          pDAT_W = 16,
  parameter int          pFRAC  = 12,
  parameter logic [31:0] pSEED0 = 32'h1234_5678,
  parameter logic [31:0] pSEED1 = 32'h9ABC_DEF1
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iclkena,
  input  logic                     irun,
`ifdef GAUS_BM_SEED_LOAD_EN
  input  logic                     iseed_load,
  input  logic [63:0]              iseed,
`endif
  output logic [8:0]               oaddr0,
  output logic [8:0]               oaddr1,
  input  logic [17:0]              idat0,
  input  logic [17:0]              idat1,
  output logic                     oval,
  output logic signed [pDAT_W-1:0] odat0,
  output logic signed [pDAT_W-1:0] odat1
);

  localparam int          cS    = 30 - pFRAC;
  localparam logic [31:0] cMASK = 32'h8020_0003;
  localparam logic [34:0] cRND  = 35'd1 << (cS - 1);
  localparam logic [34:0] cSAT  = (35'd1 << (pDAT_W - 1)) - 35'd1;

  // Sixteen right-shift Galois steps folded into one cycle
  function automatic logic [31:0] lfsrAdvance(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 16; i++) begin
      v = {1'b0, v[31:1]} ^ (v[0] ? cMASK : 32'd0);
    end
    return v;
  endfunction

  // Quarter-wave cosine sampled at bin centres, unsigned Q1.15
  function automatic logic [15:0] cosLut(input logic [3:0] k);
    logic [15:0] c;
    case (k)
      4'd0:    c = 16'd32728;
      4'd1:    c = 16'd32412;
      4'd2:    c = 16'd31785;
      4'd3:    c = 16'd30852;
      4'd4:    c = 16'd29621;
      4'd5:    c = 16'd28105;
      4'd6:    c = 16'd26319;
      4'd7:    c = 16'd24279;
      4'd8:    c = 16'd22005;
      4'd9:    c = 16'd19519;
      4'd10:   c = 16'd16846;
      4'd11:   c = 16'd14010;
      4'd12:   c = 16'd11039;
      4'd13:   c = 16'd7962;
      4'd14:   c = 16'd4808;
      default: c = 16'd1608;
    endcase
    return c;
  endfunction

  logic [31:0] r_lfsr0, r_lfsr1;
  logic [3:0]  r_ph0_d1, r_ph0_d2, r_ph1_d1, r_ph1_d2;
  logic        r_sg0_d1, r_sg0_d2, r_sg1_d1, r_sg1_d2;
  logic        r_vld_d1, r_vld_d2;
  logic [33:0] r_prod0, r_prod1;
  logic        r_sg0_m, r_sg1_m, r_vld_m;
  logic        w_issue;
  logic [34:0] w_sum0, w_sum1, w_mag0, w_mag1;
  logic [pDAT_W-1:0] w_sat0, w_sat1;

`ifdef GAUS_BM_SEED_LOAD_EN
  logic [31:0] w_seed0, w_seed1;
  assign w_seed0 = (iseed[31:0]  == 32'd0) ? pSEED0 : iseed[31:0];
  assign w_seed1 = (iseed[63:32] == 32'd0) ? pSEED1 : iseed[63:32];
  assign w_issue = irun & ~iseed_load;
`else
  assign w_issue = irun;
`endif

  assign oaddr0 = r_lfsr0[8:0];
  assign oaddr1 = r_lfsr1[8:0];

  // LFSRs advance only on an issuing cycle so every address gets a fresh state
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_lfsr0 <= pSEED0;
      r_lfsr1 <= pSEED1;
    end else if (iclkena) begin
`ifdef GAUS_BM_SEED_LOAD_EN
      if (iseed_load) begin
        r_lfsr0 <= w_seed0;
        r_lfsr1 <= w_seed1;
      end else if (w_issue) begin
`else
      if (w_issue) begin
`endif
        r_lfsr0 <= lfsrAdvance(r_lfsr0);
        r_lfsr1 <= lfsrAdvance(r_lfsr1);
      end
    end
  end

  // Two-deep phase/sign/valid delay that lines up with the table read latency
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_ph0_d1 <= '0; r_ph0_d2 <= '0; r_ph1_d1 <= '0; r_ph1_d2 <= '0;
      r_sg0_d1 <= 1'b0; r_sg0_d2 <= 1'b0; r_sg1_d1 <= 1'b0; r_sg1_d2 <= 1'b0;
      r_vld_d1 <= 1'b0; r_vld_d2 <= 1'b0;
    end else if (iclkena) begin
      r_ph0_d1 <= r_lfsr0[12:9];
      r_ph1_d1 <= r_lfsr1[12:9];
      r_sg0_d1 <= r_lfsr0[13];
      r_sg1_d1 <= r_lfsr1[13];
      r_vld_d1 <= w_issue;
      r_ph0_d2 <= r_ph0_d1;
      r_ph1_d2 <= r_ph1_d1;
      r_sg0_d2 <= r_sg0_d1;
      r_sg1_d2 <= r_sg1_d1;
      r_vld_d2 <= r_vld_d1;
    end
  end

  // Multiply stage: table magnitude times cosine of the delayed phase
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_prod0 <= '0;
      r_prod1 <= '0;
      r_sg0_m <= 1'b0;
      r_sg1_m <= 1'b0;
      r_vld_m <= 1'b0;
    end else if (iclkena) begin
      r_prod0 <= 34'(idat0) * 34'(cosLut(r_ph0_d2));
      r_prod1 <= 34'(idat1) * 34'(cosLut(r_ph1_d2));
      r_sg0_m <= r_sg0_d2;
      r_sg1_m <= r_sg1_d2;
      r_vld_m <= r_vld_d2;
    end
  end

  // Round half-up, then clamp the magnitude to the largest positive sample
  always_comb begin
    w_sum0 = {1'b0, r_prod0} + cRND;
    w_sum1 = {1'b0, r_prod1} + cRND;
    w_mag0 = w_sum0 >> cS;
    w_mag1 = w_sum1 >> cS;
    w_sat0 = (w_mag0 > cSAT) ? cSAT[pDAT_W-1:0] : w_mag0[pDAT_W-1:0];
    w_sat1 = (w_mag1 > cSAT) ? cSAT[pDAT_W-1:0] : w_mag1[pDAT_W-1:0];
  end

  // Output stage applies the random sign; data holds through bubbles
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      oval  <= 1'b0;
      odat0 <= '0;
      odat1 <= '0;
    end else if (iclkena) begin
      oval <= r_vld_m;
      if (r_vld_m) begin
        odat0 <= r_sg0_m ? -$signed(w_sat0) : $signed(w_sat0);
        odat1 <= r_sg1_m ? -$signed(w_sat1) : $signed(w_sat1);
      end
    end
  end

endmodule

// File: tb/tb_gaus_box_muller_ctrl.sv
// tb_gaus_box_muller_ctrl
// Directed bench for the Box-Muller requester. Three instances share stimulus:
// uA (pFRAC=12, seeds giving phase 0 on the first issue, address-dependent
// table stub), uS (pFRAC=14, full-scale table for saturation) and uD (default
// seeds, for reset-address checks).
module tb_gaus_box_muller_ctrl;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic ireset, iclkena, irun;

  logic [8:0]  aAddr0, aAddr1, sAddr0, sAddr1, dAddr0, dAddr1;
  logic [8:0]  aTab0, aTab1;
  logic [17:0] aDat0, aDat1;
  logic        aVal, sVal, dVal;
  logic signed [15:0] aOut0, aOut1, sOut0, sOut1, dOut0, dOut1;

  localparam logic [31:0] cSEEDA0 = 32'h0000_4000;
  localparam logic [31:0] cSEEDA1 = 32'h0000_6000;

  int cosTab[16] = '{32728, 32412, 31785, 30852, 29621, 28105, 26319, 24279,
                     22005, 19519, 16846, 14010, 11039, 7962, 4808, 1608};

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] mLfsr0, mLfsr1;
  bit          vpipe[3];
  bit          expVal;
  longint      q0[$];
  longint      q1[$];
  longint      curD0, curD1;
  bit          firstPending;

  gaus_box_muller_ctrl #(.pDAT_W(16), .pFRAC(12), .pSEED0(cSEEDA0), .pSEED1(cSEEDA1)) uA (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irun(irun),
`ifdef GAUS_BM_SEED_LOAD_EN
    .iseed_load(1'b0), .iseed(64'd0),
`endif
    .oaddr0(aAddr0), .oaddr1(aAddr1), .idat0(aDat0), .idat1(aDat1),
    .oval(aVal), .odat0(aOut0), .odat1(aOut1));

  gaus_box_muller_ctrl #(.pDAT_W(16), .pFRAC(14), .pSEED0(cSEEDA0), .pSEED1(cSEEDA1)) uS (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irun(irun),
`ifdef GAUS_BM_SEED_LOAD_EN
    .iseed_load(1'b0), .iseed(64'd0),
`endif
    .oaddr0(sAddr0), .oaddr1(sAddr1), .idat0(18'd131071), .idat1(18'd131071),
    .oval(sVal), .odat0(sOut0), .odat1(sOut1));

  gaus_box_muller_ctrl uD (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irun(irun),
`ifdef GAUS_BM_SEED_LOAD_EN
    .iseed_load(1'b0), .iseed(64'd0),
`endif
    .oaddr0(dAddr0), .oaddr1(dAddr1), .idat0(18'd32768), .idat1(18'd32768),
    .oval(dVal), .odat0(dOut0), .odat1(dOut1));

  // Table stub contents: decreasing with address so misrouted addresses show up
  function automatic logic [17:0] tabData(input logic [8:0] a);
    return 18'(32'd32768 - 32'(a) * 32'd32);
  endfunction

  // Stub of the 2-cycle table for uA: address register, then data register
  always @(posedge iclk) begin
    if (iclkena) begin
      aTab0 <= aAddr0;
      aTab1 <= aAddr1;
      aDat0 <= tabData(aTab0);
      aDat1 <= tabData(aTab1);
    end
  end

  function automatic logic [31:0] modelStep(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 16; i++) begin
      if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic longint expSample(input logic [31:0] s, input int pf, input longint d);
    longint p, m;
    int sh;
    sh = 30 - pf;
    p  = d * longint'(cosTab[s[12:9]]);
    m  = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    if (m > 32767) m = 32767;
    return s[13] ? -m : m;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, advance the model at the edge, then check just after it
  task automatic applyStimulus(input bit run, input bit ena);
    irun    = run;
    iclkena = ena;
    @(posedge iclk);
    if (ena) begin
      expVal   = vpipe[2];
      vpipe[2] = vpipe[1];
      vpipe[1] = vpipe[0];
      vpipe[0] = run;
      if (run) begin
        q0.push_back(expSample(mLfsr0, 12, longint'(tabData(mLfsr0[8:0]))));
        q1.push_back(expSample(mLfsr1, 12, longint'(tabData(mLfsr1[8:0]))));
        mLfsr0 = modelStep(mLfsr0);
        mLfsr1 = modelStep(mLfsr1);
      end
      if (expVal) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          checkOutput("queue_empty", 1, 0);
        end else begin
          curD0 = q0.pop_front();
          curD1 = q1.pop_front();
        end
      end
    end
    #1;
    checkOutput("oval", aVal, expVal);
    checkOutput("oaddr0", aAddr0, longint'(mLfsr0[8:0]));
    checkOutput("oaddr1", aAddr1, longint'(mLfsr1[8:0]));
    checkOutput("odat0", aOut0, curD0);
    checkOutput("odat1", aOut1, curD1);
    if (ena && expVal && firstPending) begin
      checkOutput("first_odat0", aOut0, 4091);
      checkOutput("first_odat1", aOut1, -4091);
      checkOutput("sat_oval", sVal, 1);
      checkOutput("sat_odat0", sOut0, 32767);
      checkOutput("sat_odat1", sOut1, -32767);
      firstPending = 1'b0;
    end
    @(negedge iclk);
  endtask

  // Assert reset for a couple of clocks and restart the model from the seeds
  task automatic doReset();
    ireset = 1'b0;
    #1;
    checkOutput("rst_oval", aVal, 0);
    checkOutput("rst_odat0", aOut0, 0);
    checkOutput("rst_odat1", aOut1, 0);
    checkOutput("rst_addrD0", dAddr0, 9'h078);
    checkOutput("rst_addrD1", dAddr1, 9'h0F1);
    checkOutput("rst_addrA0", aAddr0, 9'h000);
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    checkOutput("rst_hold_oval", aVal, 0);
    checkOutput("rst_hold_sval", sVal, 0);
    mLfsr0 = cSEEDA0;
    mLfsr1 = cSEEDA1;
    vpipe  = '{0, 0, 0};
    expVal = 1'b0;
    q0.delete();
    q1.delete();
    curD0  = 0;
    curD1  = 0;
    firstPending = 1'b1;
    ireset = 1'b1;
  endtask

  initial begin
    ireset  = 1'b1;
    iclkena = 1'b0;
    irun    = 1'b0;
    @(negedge iclk);
    doReset();

    // Idle after release: addresses stable, no valid
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_addrD0", dAddr0, 9'h078);
      checkOutput("idle_addrD1", dAddr1, 9'h0F1);
    end

    // Single issue: valid after the 4th edge, then data holds
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("lat_hold0", aOut0, 4091);
    checkOutput("lat_hold1", aOut1, -4091);

    // Bubble pattern 1,0,1,1,0
    begin
      bit pat[5] = '{1, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) applyStimulus(pat[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

    // Continuous stream with a 3-cycle clock-enable stall in the middle
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

    // Mixed run/enable pattern
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
    end

    // Reset in the middle of a full pipeline, then restart bit-exact
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    if (firstPending) checkOutput("first_seen", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/gaus_box_muller_ctrl.md
Name: gaus_box_muller_ctrl

Overview:
- Requester side of the sqrt(-2ln u) log-table interface, and the core of the Box-Muller AWGN source.
- Holds two uniform generators and drives the two 9-bit table address ports.
- Takes the 18-bit table magnitudes back after the table's fixed 2-cycle read latency.
- Multiplies each magnitude by a random-signed cosine from an internal quarter-wave table, then rounds and saturates to two signed Gaussian samples per cycle.

Parameters:
pDAT_W, 16, output sample width (signed)
pFRAC, 12, output fractional bits (1.0 sigma = 2^pFRAC)
pSEED0, 32'h1234_5678, reset seed of LFSR0 (nonzero)
pSEED1, 32'h9ABC_DEF1, reset seed of LFSR1 (nonzero)

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous reset, active-low (asserted when 0)
iclkena  in  1  clock enable; also drives the table's iclkena
irun  in  1  issue one sample pair this enabled cycle
oaddr0  out  9  log table address, port 0
oaddr1  out  9  log table address, port 1
idat0  in  18  table data port 0, unsigned Q3.15
idat1  in  18  table data port 1, unsigned Q3.15
oval  out  1  odat0/odat1 valid
odat0  out  pDAT_W  Gaussian sample 0, signed
odat1  out  pDAT_W  Gaussian sample 1, signed

Behaviour:
- Reset (ireset=0, async):
  - LFSR0 <= pSEED0, LFSR1 <= pSEED1.
  - Valid pipe cleared; oval=0; odat0=odat1=0.
  - Effective even mid-pipeline; no partial samples emerge after release.
- iclkena=0: every register holds, including LFSRs, valid pipe and outputs.
- LFSRn: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - Advances 16 unrolled steps per cycle with iclkena=1 and irun=1; holds otherwise.
- Fields taken from the current LFSRn state (combinational from registers):
  - addr = state[8:0], driven on oaddrn.
  - phase = state[12:9].
  - sign = state[13].
- Issue: at an enabled edge with irun=1 the table captures oaddrn; phase, sign and a valid bit enter a 2-deep delay matched to the table.
- Table return: idatn is valid after the next enabled edge, aligned with the delayed phase/sign/valid.
- Cosine table: 16-entry internal constant ROM, cos[k] = round(32767*cos(pi/2*(k+0.5)/16)), unsigned Q1.15.
  - Entry 0 = 32728.
- Stage M (registered): P = idatn * cos[phase], unsigned 34-bit.
- Stage R (registered), with S = 30 - pFRAC:
  - mag = (P + 2^(S-1)) >> S.
  - Saturate mag to 2^(pDAT_W-1)-1.
  - odatn = sign ? -mag : mag.
  - oval = delayed valid.
- Latency: issuing edge counts as edge 1; oval=1 and data appear after edge 4. One pair per enabled cycle is sustained.
- irun=0 cycles produce oval=0 bubbles in order; odat holds its last value when oval=0.
- Address 0 (table max) and 511 (table value 0 -> output 0) are legal; no special casing.
- Sample 0 and sample 1 use independent LFSRs; there is no sin branch.

Optional Feature:
- Macro: GAUS_BM_SEED_LOAD_EN.
- Defined: adds ports iseed_load (in, 1) and iseed (in, 64).
  - At an enabled edge with iseed_load=1: LFSR0 <= iseed[31:0], LFSR1 <= iseed[63:32].
  - A zero half is replaced by the matching pSEEDn.
  - iseed_load has priority over irun; no issue occurs that cycle; in-flight samples complete normally.
- Undefined: ports absent; seeds come only from parameters at reset.

Test Plan:
- Reset: hold ireset=0 -> oval=0, odat0=odat1=0, oaddr0=9'h078, oaddr1=9'h0F1. Release with irun=0 for 10 cycles -> oaddr stable, oval stays 0.
- Latency: stub table, 2-cycle, constant 32768; force phase 0, sign 0 via seed; single irun pulse -> oval high exactly after 4th edge, odat=4091; sign=1 -> -4091.
- Saturation: pFRAC=14, idat=131071, phase 0 -> P=4289691688, mag 65456 -> odat=32767 / -32767.
- Stall: toggle iclkena 0 for 3 cycles mid-stream with irun=1 -> output sequence identical to the unstalled run, no duplicates or drops.
- Bubbles: irun pattern 1,0,1,1,0 -> oval pattern identical, delayed 4 cycles.
- Statistics: real log table, 2^20 samples, pFRAC=12 -> mean within +/-20, std within 4096+/-2%, both outputs; reset mid-run -> sequence restarts bit-exact.
